div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits (legal range 8..64).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port signed_div  input  1  1 = two's-complement divide, 0 = unsigned divide; sampled only at start.
REQ-005 SHALL provide port start  input  1  request a divide; accepted only in IDLE.
REQ-006 SHALL provide port annul  input  1  cancel the divide in progress (pipeline flush).
REQ-007 SHALL provide port opdata1  input  WIDTH  dividend; sampled only at start.
REQ-008 SHALL provide port opdata2  input  WIDTH  divisor; sampled only at start.
REQ-009 SHALL provide port result  output  2*WIDTH  {remainder, quotient}, with remainder bound for LO-high/HI.
REQ-010 SHALL provide port ready  output  1  one-cycle pulse marking result valid.
REQ-011 SHALL provide port stall_req  output  1  combinational request to stall the pipeline.

Function
REQ-012 SHALL implement a four-state FSM with states IDLE, DIVZERO, ON and END.
REQ-013 In IDLE with start=1 and opdata2=0, SHALL go to DIVZERO.
REQ-014 In IDLE with start=1 and opdata2!=0, SHALL latch operand magnitudes, clear the iteration counter, and go to ON.
REQ-015 In IDLE with start=0, SHALL remain in IDLE; start in any other state SHALL be ignored.
REQ-016 ON SHALL perform one radix-2 restoring shift/subtract step per cycle for exactly WIDTH cycles (counter 0..WIDTH-1, counter width clog2(WIDTH)+1), then go to END.
REQ-017 DIVZERO SHALL last one cycle, then go to END with quotient=0 and remainder=0.
REQ-018 END SHALL register the result, drive ready=1 for that cycle only, and return to IDLE.
REQ-019 Latency: ready SHALL be high exactly WIDTH+1 cycles after the start edge (2 cycles for divide-by-zero).
REQ-020 stall_req SHALL equal (state==IDLE && start && !annul) || state==DIVZERO || state==ON; it SHALL be 0 in END.
REQ-021 annul=1 in DIVZERO or ON SHALL return the FSM to IDLE on the next edge, with no ready pulse and result unchanged.
REQ-022 annul=1 together with start in IDLE SHALL block acceptance of the start.
REQ-023 annul in END SHALL NOT suppress the ready pulse.
REQ-024 Signed mode SHALL divide absolute values.
REQ-025 In signed mode, the quotient SHALL be negated iff the operand signs differ.
REQ-026 In signed mode, the remainder SHALL be negated iff the dividend is negative, so the remainder takes the sign of the dividend.
REQ-027 Signed most-negative / -1 SHALL give quotient = most-negative (wrap-around) and remainder 0, with no trap.
REQ-028 Unsigned mode SHALL treat both operands as zero-extended.
REQ-029 result SHALL hold its last value between ready pulses and through annulled operations.
REQ-030 Operand inputs SHALL be free to change after the start cycle without affecting the divide in progress.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE, counter=0, result=0 and ready=0, independent of clk.
REQ-032 During reset, stall_req SHALL follow REQ-020 with state=IDLE.
REQ-033 Reset asserted mid-operation SHALL abandon the divide with no ready pulse.
REQ-034 After release of reset, the first start SHALL be accepted on the first rising edge.

Verification (WIDTH=32)
REQ-035 SHALL cover: unsigned 100/7 -> ready at cycle 33 after start, result={32'd2, 32'd14}, stall_req high during cycles 0..32.
REQ-036 SHALL cover: signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned 0xFFFFFFF9/2 -> quotient 0x7FFFFFFC, remainder 1.
REQ-037 SHALL cover: divisor 0 in both modes -> ready at cycle 2, result=0, stall_req low in END.
REQ-038 SHALL cover: signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-039 SHALL cover: annul at ON cycle 10 -> IDLE next cycle, no ready, result retains the prior value; a new start 1 cycle later completes normally.
REQ-040 SHALL cover: rst low at ON cycle 5 -> result=0 and ready=0 asynchronously; after release, back-to-back starts issued one cycle after each END complete correctly.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider producing one quotient bit per clock.
// Signed operands are divided as magnitudes; signs are restored as the result is registered.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div,
  input  logic               start,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t                state, nextState;
  logic [CNT_W-1:0]      cnt;
  logic [WIDTH-1:0]      divisorMag, quoReg, remReg;
  logic                  negQuo, negRem;
  logic [WIDTH:0]        partial;
  logic signed [WIDTH:0] diff;
  logic                  qBit;
  logic [WIDTH-1:0]      quoNext, remNext;
  logic                  accept, lastStep, zeroDone;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic isSigned);
    return (isSigned && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign accept    = (state == IDLE) && start && !annul;
  assign lastStep  = (state == ON) && !annul && (cnt == LAST_CNT);
  assign zeroDone  = (state == DIVZERO) && !annul;
  assign stall_req = accept || (state == DIVZERO) || (state == ON);

  // Restoring step: shift next dividend bit into the partial remainder and try the subtract.
  always_comb begin
    partial = {remReg, quoReg[WIDTH-1]};
    diff    = $signed(partial - {1'b0, divisorMag});
    qBit    = ~diff[WIDTH];
    remNext = qBit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    quoNext = {quoReg[WIDTH-2:0], qBit};
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start && !annul) nextState = (opdata2 == '0) ? DIVZERO : ON;
      DIVZERO: nextState = annul ? IDLE : END;
      ON: begin
        if (annul)                 nextState = IDLE;
        else if (cnt == LAST_CNT)  nextState = END;
      end
      END:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      state <= nextState;
      ready <= lastStep || zeroDone;
      if (accept)
        cnt <= '0;
      else if ((state == ON) && !annul)
        cnt <= cnt + CNT_W'(1);
      // Result lands on the edge into END so ready and result appear together.
      if (lastStep)
        result <= {applySign(remNext, negRem), applySign(quoNext, negQuo)};
      else if (zeroDone)
        result <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      divisorMag <= magnitude(opdata2, signed_div);
      quoReg     <= magnitude(opdata1, signed_div);
      remReg     <= '0;
      negQuo     <= signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
      negRem     <= signed_div && opdata1[WIDTH-1];
    end else if (state == ON) begin
      quoReg <= quoNext;
      remReg <= remNext;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit at WIDTH=32: expected results queued at start, checked at ready.
module tb_div_unit;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div, start, annul;
  logic [W-1:0]   opdata1, opdata2;
  logic [2*W-1:0] result;
  logic           ready, stall_req;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] expQ[$];

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .signed_div(signed_div), .start(start), .annul(annul),
    .opdata1(opdata1), .opdata2(opdata2), .result(result), .ready(ready), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  task automatic issueStart(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                            input logic [2*W-1:0] exp, output logic stall0);
    @(posedge clk); #1;
    start = 1'b1; opdata1 = a; opdata2 = b; signed_div = sgn;
    expQ.push_back(exp);
    @(negedge clk);
    stall0 = stall_req;
    @(posedge clk); #1;
    start = 1'b0; opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom_range(0, 1));
  endtask

  task automatic waitReady(output int lat, output logic [2*W-1:0] res, output bit stallBad);
    lat = -1; res = 'x; stallBad = 1'b0;
    for (int n = 1; n <= 3 * W; n++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        lat = n; res = result;
        if (stall_req !== 1'b0) stallBad = 1'b1;
        break;
      end
      if (stall_req !== 1'b1) stallBad = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; annul = 1'b0; signed_div = 1'b0; opdata1 = 32'd9; opdata2 = 32'd3;
    #1 rst = 1'b0;
    #1;
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL reset_stall_start: got %b expected 1", stall_req); end
    annul = 1'b1; #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall_annul: got %b expected 0", stall_req); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0 || result !== '0) begin errors++; $display("FAIL reset_held: ready %b result %h expected 0/0", ready, result); end
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0; rst = 1'b1;
  endtask

  task automatic test_unsigned_basic();
    logic s0; int lat; logic [2*W-1:0] res, exp; bit sb;
    issueStart(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, s0);
    waitReady(lat, res, sb);
    exp = expQ.pop_front();
    checks++; if (s0 !== 1'b1) begin errors++; $display("FAIL u100_7_stall0: got %b expected 1", s0); end
    checks++; if (lat != 33) begin errors++; $display("FAIL u100_7_latency: got %0d expected 33", lat); end
    checks++; if (res !== exp) begin errors++; $display("FAIL u100_7_result: got %h expected %h", res, exp); end
    checks++; if (sb) begin errors++; $display("FAIL u100_7_stall: got bad stall pattern expected high until END"); end
    @(negedge clk);
    checks++; if (ready !== 1'b0 || result !== exp) begin errors++; $display("FAIL u100_7_hold: ready %b result %h expected 0 / %h", ready, result, exp); end
  endtask

  task automatic test_signed();
    logic s0; int lat; logic [2*W-1:0] res, exp; bit sb;
    issueStart(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, s0);
    waitReady(lat, res, sb);
    exp = expQ.pop_front();
    checks++; if (res !== exp || lat != 33) begin errors++; $display("FAIL s_m7_2: got %h lat %0d expected %h lat 33", res, lat, exp); end
    issueStart(32'hFFFF_FFF9, 32'd2, 1'b0, {32'd1, 32'h7FFF_FFFC}, s0);
    waitReady(lat, res, sb);
    exp = expQ.pop_front();
    checks++; if (res !== exp || lat != 33) begin errors++; $display("FAIL u_fff9_2: got %h lat %0d expected %h lat 33", res, lat, exp); end
    issueStart(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, s0);
    waitReady(lat, res, sb);
    exp = expQ.pop_front();
    checks++; if (res !== exp) begin errors++; $display("FAIL s_7_m2: got %h expected %h", res, exp); end
  endtask

  task automatic test_divzero();
    logic s0; int lat; logic [2*W-1:0] res, exp; bit sb;
    for (int m = 0; m < 2; m++) begin
      issueStart(32'h1234_5678 + 32'(m), 32'd0, 1'(m), '0, s0);
      waitReady(lat, res, sb);
      exp = expQ.pop_front();
      checks++; if (lat != 2) begin errors++; $display("FAIL divzero_latency mode %0d: got %0d expected 2", m, lat); end
      checks++; if (res !== exp) begin errors++; $display("FAIL divzero_result mode %0d: got %h expected %h", m, res, exp); end
      checks++; if (sb || s0 !== 1'b1) begin errors++; $display("FAIL divzero_stall mode %0d: start stall %b, pattern bad %0d expected 1 / 0", m, s0, sb); end
    end
  endtask

  task automatic test_overflow();
    logic s0; int lat; logic [2*W-1:0] res, exp; bit sb;
    issueStart(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, s0);
    waitReady(lat, res, sb);
    exp = expQ.pop_front();
    checks++; if (res !== exp) begin errors++; $display("FAIL s_minneg_m1: got %h expected %h", res, exp); end
    issueStart(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, model(32'h8000_0000, 32'hFFFF_FFFF, 1'b0), s0);
    waitReady(lat, res, sb);
    exp = expQ.pop_front();
    checks++; if (res !== exp) begin errors++; $display("FAIL u_8000_ffff: got %h expected %h", res, exp); end
  endtask

  task automatic test_annul();
    logic s0; int lat; logic [2*W-1:0] res, exp, prior, dropped; bit sb;
    prior = model(32'd1000, 32'd3, 1'b0);
    issueStart(32'd1000, 32'd3, 1'b0, prior, s0);
    waitReady(lat, res, sb);
    exp = expQ.pop_front();
    checks++; if (res !== exp) begin errors++; $display("FAIL annul_prior: got %h expected %h", res, exp); end
    issueStart(32'd12345, 32'd17, 1'b0, model(32'd12345, 32'd17, 1'b0), s0);
    dropped = expQ.pop_back();
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk); #1 annul = 1'b0;
    @(negedge clk);
    checks++; if (stall_req !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL annul_idle: stall %b ready %b expected 0/0", stall_req, ready); end
    checks++; if (result !== prior) begin errors++; $display("FAIL annul_result_kept: got %h expected %h (dropped %h)", result, prior, dropped); end
    issueStart(32'hDEAD_BEEF, 32'd255, 1'b0, model(32'hDEAD_BEEF, 32'd255, 1'b0), s0);
    waitReady(lat, res, sb);
    exp = expQ.pop_front();
    checks++; if (res !== exp || lat != 33 || sb) begin errors++; $display("FAIL annul_restart: got %h lat %0d expected %h lat 33", res, lat, exp); end
  endtask

  task automatic test_annul_start();
    logic s0; int lat; logic [2*W-1:0] res, exp; bit bad;
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5; signed_div = 1'b0;
    @(negedge clk);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL annul_start_stall: got %b expected 0", stall_req); end
    @(posedge clk); #1 start = 1'b0; annul = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ready !== 1'b0 || stall_req !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL annul_start_blocked: got activity expected idle"); end
    issueStart(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, s0);
    waitReady(lat, res, bad);
    exp = expQ.pop_front();
    checks++; if (res !== exp || lat != 33) begin errors++; $display("FAIL annul_start_after: got %h lat %0d expected %h lat 33", res, lat, exp); end
  endtask

  task automatic test_reset_mid();
    logic s0; int lat; logic [2*W-1:0] res, exp, dropped; bit sb;
    logic [W-1:0] a, b; logic sg;
    issueStart(32'd999, 32'd10, 1'b0, model(32'd999, 32'd10, 1'b0), s0);
    dropped = expQ.pop_back();
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (result !== '0 || ready !== 1'b0) begin errors++; $display("FAIL reset_mid_async: result %h ready %b expected 0/0 (dropped %h)", result, ready, dropped); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_mid_stall: got %b expected 0", stall_req); end
    @(posedge clk); #1 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = $urandom; b = (k == 0) ? 32'd1 : 32'($urandom_range(1, 70000)); sg = 1'(k);
      issueStart(a, b, sg, model(a, b, sg), s0);
      waitReady(lat, res, sb);
      exp = expQ.pop_front();
      checks++; if (res !== exp || lat != 33 || sb) begin errors++; $display("FAIL b2b_%0d: got %h lat %0d expected %h lat 33", k, res, lat, exp); end
    end
  endtask

  task automatic test_random();
    logic s0; int lat; logic [2*W-1:0] res, exp; bit sb;
    logic [W-1:0] a, b; logic sg;
    for (int k = 0; k < 12; k++) begin
      a = $urandom;
      b = (k % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (k == 5) b = 32'hFFFF_FFFF;
      sg = 1'(k % 2);
      issueStart(a, b, sg, model(a, b, sg), s0);
      waitReady(lat, res, sb);
      exp = expQ.pop_front();
      checks++; if (res !== exp || lat != 33) begin errors++; $display("FAIL rand_%0d %h/%h s%0d: got %h lat %0d expected %h", k, a, b, sg, res, lat, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_divzero();
    test_overflow();
    test_annul();
    test_annul_start();
    test_reset_mid();
    test_random();
    checks++; if (expQ.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries expected 0", expQ.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
